spi_xfer_master: RTL and testbench
==================================

Name: spi_xfer_master

Overview:
- SPI initiator (mode 0: CPOL=0, CPHA=0) that drives sck, ss_n and mosi and samples miso. It is the controller-side counterpart of the team's SPI peripheral devices, such as the bit-reversal responder.
- Takes one transfer request over a valid/ready port, shifts 1..DATA_W bits full-duplex, then returns the received word over a valid/ready response port.
- Sits between the SPI APB/AXI register front-end and the off-chip or simulated SPI devices.

Parameters:
- DATA_W, 64, maximum bits per transfer; width of tx/rx data.
- LEN_W, 6, width of req_len; equals clog2(DATA_W).
- SS_W, 8, number of slave-select lines.
- DIV_W, 8, width of the clock-divider field.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  transfer request valid.
- req_ready  out  1  high only in IDLE.
- req_tx_data  in  DATA_W  bits to send.
- req_len  in  LEN_W  transfer length minus 1 (n = req_len+1 bits).
- req_lsb  in  1  1 = LSB first, 0 = MSB first.
- req_ss  in  SS_W  one-hot or multi-hot select mask; driven active-low on ss_n.
- req_div  in  DIV_W  half-period H = req_div+1 clock cycles.
- rsp_valid  out  1  received data valid.
- rsp_ready  in  1  response consumer ready.
- rsp_rx_data  out  DATA_W  received bits, right-aligned, upper bits zero.
- sck  out  1  SPI clock, idles low.
- ss_n  out  SS_W  active-low selects.
- mosi  out  1  serial data out.
- miso  in  1  serial data in.

Behaviour:
- Reset (async, any state):
  - state=IDLE; sck=0; ss_n=all 1; mosi=1; rsp_valid=0; rsp_rx_data=0; counters=0; req_ready=1 after reset.
  - Asserting reset mid-transfer aborts it immediately: no response is produced and ss_n deasserts asynchronously.
- All request fields are latched on the req_valid && req_ready edge. Inputs are ignored outside IDLE.
- States:
  - IDLE -> SETUP on handshake.
  - SETUP: ss_n = ~req_ss; mosi = first bit; sck=0; H cycles -> HIGH.
  - HIGH: sck=1; miso is sampled on the edge entering HIGH; H cycles. Then if bits_done == n go to HOLD, else go to LOW.
  - LOW: sck=0; mosi updated to the next bit on the edge entering LOW; H cycles -> HIGH.
  - HOLD: sck=0; ss_n still asserted; mosi keeps its last bit; H cycles -> DONE.
  - DONE: ss_n=all 1; mosi=1; rsp_valid=1; stay until rsp_ready, then go to IDLE.
- Timing:
  - ss_n is low for exactly H*(2n+1) cycles.
  - Exactly n sck rising edges.
  - Handshake to rsp_valid latency = H*(2n+1)+1 cycles.
- Bit order:
  - MSB first: send tx[n-1]..tx[0]; the k-th received bit (k=0..n-1) goes to rx[n-1-k].
  - LSB first: send tx[0]..tx[n-1]; the k-th received bit goes to rx[k].
  - Bits of tx above n-1 are ignored; rx bits above n-1 are 0.
- Divider counter is DIV_W+1 bits wide, so req_div = all-ones gives H = 2^DIV_W without overflow.
- Response stays stable while rsp_valid && !rsp_ready. No new request is accepted until the response is consumed (req_ready=0 in DONE).
- n=1 (req_len=0): SETUP, HIGH, HOLD, DONE; one sck pulse.
- req_ss=0: the transfer runs normally but no select is asserted.

Optional Feature:
- Macro SPI_XFER_MASTER_SS_HOLD_EN.
- Defined:
  - Adds input req_hold (1 bit), latched with the request.
  - If req_hold=1, DONE keeps ss_n asserted, keeps sck=0 and mosi=1, and the next accepted request skips SETUP, entering LOW-equivalent timing (first bit driven, H cycles, then HIGH). This allows multi-word frames, e.g. flash command + address + data.
  - A following request with a different req_ss first deasserts ss_n for H cycles, then performs a normal SETUP.
- Undefined: req_hold is absent; ss_n always deasserts in DONE.

Decomposition:
- Shared package spi_pkg holds:
  - state enum (IDLE, SETUP, HIGH, LOW, HOLD, DONE);
  - SPI_IDLE_MOSI=1'b1 and SCK_IDLE=1'b0 constants;
  - default DATA_W/SS_W/DIV_W values.
- One natural sub-module, spi_clk_div: loadable half-period down-counter with a tick output, reused by the flash/XIP front-end.

Test Plan:
- Loopback (miso=mosi), tx=0xA5, len=7, MSB, div=0, ss=8'h01 -> 8 sck pulses; ss_n[0] low 17 cycles; rsp_rx_data=0x00..A5; ss_n=8'hFF after.
- Bit-reversal SPI responder on ss[0], 16-bit MSB transfer, tx=0x00A5 (responder receives the 8-bit frame LSB first), div=1 -> rx[7:0]=0xA5 and the responder's reversed byte appears in rx bits per the responder's timing; H=2 is checked on sck high/low widths.
- LSB first, len=0, tx=1, miso tied 0 -> exactly one sck pulse; mosi=1 during it; rx=0; latency=H*3+1.
- Back-pressure: rsp_ready=0 for 10 cycles -> rsp_valid and rsp_rx_data stable; req_ready=0; new req_valid ignored until the pop.
- Reset asserted during the 4th HIGH of an 8-bit transfer -> same-cycle (async) sck=0, ss_n=all 1, mosi=1; no rsp_valid; next request completes normally.
- div=8'hFF, len=63 -> H=256; ss_n low 256*129 cycles; no counter wrap; 64 pulses.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI transfer master and its helper blocks.
package spi_pkg;

    localparam int unsigned DEF_DATA_W = 64;
    localparam int unsigned DEF_LEN_W  = 6;
    localparam int unsigned DEF_SS_W   = 8;
    localparam int unsigned DEF_DIV_W  = 8;

    localparam logic SPI_IDLE_MOSI = 1'b1;
    localparam logic SCK_IDLE      = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        HOLD,
        DONE
    } spi_state_e;

endpackage

// File: rtl/spi_xfer_master_if.sv
// Request/response handshake plus SPI pin bundle for spi_xfer_master.
// With SPI_XFER_MASTER_SS_HOLD_EN defined the request also carries req_hold.
interface spi_xfer_master_if #(
    parameter int unsigned DATA_W = spi_pkg::DEF_DATA_W,
    parameter int unsigned LEN_W  = spi_pkg::DEF_LEN_W,
    parameter int unsigned SS_W   = spi_pkg::DEF_SS_W,
    parameter int unsigned DIV_W  = spi_pkg::DEF_DIV_W
);

    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] req_tx_data;
    logic [LEN_W-1:0]  req_len;
    logic              req_lsb;
    logic [SS_W-1:0]   req_ss;
    logic [DIV_W-1:0]  req_div;
`ifdef SPI_XFER_MASTER_SS_HOLD_EN
    logic              req_hold;
`endif
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rx_data;
    logic              sck;
    logic [SS_W-1:0]   ss_n;
    logic              mosi;
    logic              miso;

    // Front-end side: issues requests and consumes responses.
    modport master (
`ifdef SPI_XFER_MASTER_SS_HOLD_EN
        output req_hold,
`endif
        output req_valid, req_tx_data, req_len, req_lsb, req_ss, req_div, rsp_ready,
        input  req_ready, rsp_valid, rsp_rx_data
    );

    // Transfer engine side: serves requests and drives the SPI pins.
    modport slave (
`ifdef SPI_XFER_MASTER_SS_HOLD_EN
        input  req_hold,
`endif
        input  req_valid, req_tx_data, req_len, req_lsb, req_ss, req_div, rsp_ready, miso,
        output req_ready, rsp_valid, rsp_rx_data, sck, ss_n, mosi
    );

    // Off-chip or simulated SPI device side.
    modport dev (
        input  sck, ss_n, mosi,
        output miso
    );

endinterface

// File: rtl/spi_clk_div.sv
// Loadable half-period down-counter; tick_c marks the last cycle of a loaded period.
module spi_clk_div #(
    parameter int unsigned CNT_W = 9
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tick_c
);

    logic [CNT_W-1:0] cnt;

    // Saturates at zero so an unloaded counter never produces spurious ticks.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign tick_c = (cnt == CNT_W'(1));

endmodule

// File: rtl/spi_xfer_master.sv
// SPI mode-0 initiator: one valid/ready request, 1..DATA_W full-duplex bits, one response.
// Optional SPI_XFER_MASTER_SS_HOLD_EN keeps the select asserted across requests for multi-word frames.
module spi_xfer_master
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned LEN_W  = DEF_LEN_W,
    parameter int unsigned SS_W   = DEF_SS_W,
    parameter int unsigned DIV_W  = DEF_DIV_W
) (
    input logic              clock,
    input logic              reset,
    spi_xfer_master_if.slave bus
);

    localparam int unsigned CNT_W = DIV_W + 1;
    localparam int unsigned BIT_W = LEN_W + 1;

    spi_state_e        state, state_d;
    logic              sck, sck_d;
    logic              mosi, mosi_d;
    logic              rsp_valid, rsp_valid_d;
    logic              ready;
    logic [SS_W-1:0]   ss_n, ss_n_d;

    logic [DATA_W-1:0] tx_q, rx_sh, rx_data;
    logic [LEN_W-1:0]  len_q, next_idx_c;
    logic              lsb_q;
    logic [DIV_W-1:0]  div_q;
    logic [BIT_W-1:0]  bits_done, n_c;

    logic              accept_c, sample_c, finish_c, div_load_c, tick_c;
    logic              first_bit_c, next_bit_c;
    logic [CNT_W-1:0]  div_val_c;

`ifdef SPI_XFER_MASTER_SS_HOLD_EN
    logic              hold_q, linked, linked_d, gap, gap_d;
    logic [SS_W-1:0]   ss_q;
    logic              tx_first_c;
`endif

    spi_clk_div #(
        .CNT_W (CNT_W)
    ) u_clk_div (
        .clock    (clock),
        .reset    (reset),
        .load     (div_load_c),
        .load_val (div_val_c),
        .tick_c   (tick_c)
    );

    assign n_c         = BIT_W'(len_q) + BIT_W'(1);
    assign first_bit_c = bus.req_lsb ? bus.req_tx_data[0] : bus.req_tx_data[bus.req_len];
    // bits_done is already the index of the bit to present when HIGH ends.
    assign next_idx_c  = lsb_q ? bits_done[LEN_W-1:0] : len_q - bits_done[LEN_W-1:0];
    assign next_bit_c  = tx_q[next_idx_c];
`ifdef SPI_XFER_MASTER_SS_HOLD_EN
    assign tx_first_c  = lsb_q ? tx_q[0] : tx_q[len_q];
`endif

    always_comb begin
        state_d     = state;
        sck_d       = sck;
        ss_n_d      = ss_n;
        mosi_d      = mosi;
        rsp_valid_d = rsp_valid;
        accept_c    = 1'b0;
        sample_c    = 1'b0;
        finish_c    = 1'b0;
        div_load_c  = 1'b0;
        div_val_c   = CNT_W'(div_q) + CNT_W'(1);
`ifdef SPI_XFER_MASTER_SS_HOLD_EN
        linked_d    = linked;
        gap_d       = gap;
`endif
        unique case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    accept_c   = 1'b1;
                    div_load_c = 1'b1;
                    div_val_c  = CNT_W'(bus.req_div) + CNT_W'(1);
                    state_d    = SETUP;
                    ss_n_d     = ~bus.req_ss;
                    mosi_d     = first_bit_c;
`ifdef SPI_XFER_MASTER_SS_HOLD_EN
                    linked_d   = 1'b0;
                    if (linked && (bus.req_ss == ss_q)) begin
                        state_d = LOW;
                        ss_n_d  = ss_n;
                    end else if (linked) begin
                        gap_d   = 1'b1;
                        ss_n_d  = '1;
                        mosi_d  = SPI_IDLE_MOSI;
                    end
`endif
                end
            end
            SETUP: begin
                if (tick_c) begin
                    div_load_c = 1'b1;
                    state_d    = HIGH;
                    sck_d      = ~SCK_IDLE;
                    sample_c   = 1'b1;
`ifdef SPI_XFER_MASTER_SS_HOLD_EN
                    // Select-change gap: release done, now run a normal setup period.
                    if (gap) begin
                        state_d  = SETUP;
                        sck_d    = SCK_IDLE;
                        sample_c = 1'b0;
                        gap_d    = 1'b0;
                        ss_n_d   = ~ss_q;
                        mosi_d   = tx_first_c;
                    end
`endif
                end
            end
            HIGH: begin
                if (tick_c) begin
                    div_load_c = 1'b1;
                    sck_d      = SCK_IDLE;
                    if (bits_done == n_c) begin
                        state_d = HOLD;
                    end else begin
                        state_d = LOW;
                        mosi_d  = next_bit_c;
                    end
                end
            end
            LOW: begin
                if (tick_c) begin
                    div_load_c = 1'b1;
                    state_d    = HIGH;
                    sck_d      = ~SCK_IDLE;
                    sample_c   = 1'b1;
                end
            end
            HOLD: begin
                if (tick_c) begin
                    state_d     = DONE;
                    finish_c    = 1'b1;
                    rsp_valid_d = 1'b1;
                    ss_n_d      = '1;
                    mosi_d      = SPI_IDLE_MOSI;
`ifdef SPI_XFER_MASTER_SS_HOLD_EN
                    if (hold_q) begin
                        ss_n_d   = ss_n;
                        linked_d = 1'b1;
                    end
`endif
                end
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            sck       <= SCK_IDLE;
            ss_n      <= '1;
            mosi      <= SPI_IDLE_MOSI;
            rsp_valid <= 1'b0;
            ready     <= 1'b1;
`ifdef SPI_XFER_MASTER_SS_HOLD_EN
            linked    <= 1'b0;
            gap       <= 1'b0;
`endif
        end else begin
            state     <= state_d;
            sck       <= sck_d;
            ss_n      <= ss_n_d;
            mosi      <= mosi_d;
            rsp_valid <= rsp_valid_d;
            ready     <= (state_d == IDLE);
`ifdef SPI_XFER_MASTER_SS_HOLD_EN
            linked    <= linked_d;
            gap       <= gap_d;
`endif
        end
    end

    // Request latch and receive shifter; LSB-first bits land at their final index directly.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_q      <= '0;
            len_q     <= '0;
            lsb_q     <= 1'b0;
            div_q     <= '0;
            bits_done <= '0;
            rx_sh     <= '0;
            rx_data   <= '0;
`ifdef SPI_XFER_MASTER_SS_HOLD_EN
            hold_q    <= 1'b0;
            ss_q      <= '0;
`endif
        end else begin
            if (accept_c) begin
                tx_q      <= bus.req_tx_data;
                len_q     <= bus.req_len;
                lsb_q     <= bus.req_lsb;
                div_q     <= bus.req_div;
                bits_done <= '0;
                rx_sh     <= '0;
`ifdef SPI_XFER_MASTER_SS_HOLD_EN
                hold_q    <= bus.req_hold;
                ss_q      <= bus.req_ss;
`endif
            end
            if (sample_c) begin
                bits_done <= bits_done + BIT_W'(1);
                if (lsb_q) begin
                    rx_sh[bits_done[LEN_W-1:0]] <= bus.miso;
                end else begin
                    rx_sh <= {rx_sh[DATA_W-2:0], bus.miso};
                end
            end
            if (finish_c) begin
                rx_data <= rx_sh;
            end
        end
    end

    assign bus.req_ready   = ready;
    assign bus.rsp_valid   = rsp_valid;
    assign bus.rsp_rx_data = rx_data;
    assign bus.sck         = sck;
    assign bus.ss_n        = ss_n;
    assign bus.mosi        = mosi;

endmodule

// File: tb/tb_spi_xfer_master.sv
// Randomized self-checking bench for spi_xfer_master against a transfer-level reference model.
module tb_spi_xfer_master;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned LEN_W  = 6;
    localparam int unsigned SS_W   = 8;
    localparam int unsigned DIV_W  = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic loop_mode = 1'b1;
    logic pat_bit = 1'b0;
    int   total = 0;
    int   bad   = 0;

    spi_xfer_master_if #(
        .DATA_W (DATA_W), .LEN_W (LEN_W), .SS_W (SS_W), .DIV_W (DIV_W)
    ) bus ();

    spi_xfer_master #(
        .DATA_W (DATA_W), .LEN_W (LEN_W), .SS_W (SS_W), .DIV_W (DIV_W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Device model: either a wire loopback or a pre-drawn bit stream advanced per sck rise.
    assign bus.miso = loop_mode ? bus.mosi : pat_bit;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_xfer(input logic [63:0] tx, input int len, input bit lsb, input logic [7:0] ss,
                            input logic [7:0] div, input bit loop, input logic [63:0] pat, input int bp);
        int n, h, cyc, rises, ss_low, ss_bad, hi_run, width_bad, limit, stable_bad;
        logic prev_sck;
        logic [63:0] sent, exp_rx, exp_sent, mask;
        n = len + 1;
        h = int'(div) + 1;
        mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
        exp_rx = '0;
        exp_sent = '0;
        sent = '0;
        for (int k = 0; k < n; k++) begin
            exp_sent[k] = lsb ? tx[k] : tx[n-1-k];
            if (!loop) begin
                if (lsb) exp_rx[k] = pat[k];
                else     exp_rx[n-1-k] = pat[k];
            end
        end
        if (loop) exp_rx = tx & mask;

        @(negedge clock);
        loop_mode = loop;
        pat_bit = pat[0];
        bus.rsp_ready = (bp == 0);
        bus.req_tx_data = tx;
        bus.req_len = 6'(len);
        bus.req_lsb = lsb;
        bus.req_ss = ss;
        bus.req_div = div;
        bus.req_valid = 1'b1;
        chk("req_ready_idle", 64'(bus.req_ready), 64'd1);
        @(negedge clock);
        bus.req_valid = 1'b0;
        bus.req_tx_data = {$urandom, $urandom};
        bus.req_len = 6'($urandom);
        bus.req_lsb = ~lsb;

        cyc = 1; rises = 0; ss_low = 0; ss_bad = 0; hi_run = 0; width_bad = 0;
        prev_sck = 1'b0;
        limit = h * (2 * n + 1) + 50;
        while (bus.rsp_valid !== 1'b1 && cyc <= limit) begin
            if (bus.ss_n !== 8'hFF) begin
                ss_low++;
                if (bus.ss_n !== ~ss) ss_bad++;
            end
            if (bus.sck === 1'b1) begin
                if (prev_sck === 1'b0) begin
                    if (rises < 64) sent[rises] = bus.mosi;
                    rises++;
                    if (rises < 64) pat_bit = pat[rises];
                    hi_run = 0;
                end
                hi_run++;
            end else if (prev_sck === 1'b1 && hi_run != h) begin
                width_bad++;
            end
            prev_sck = bus.sck;
            @(negedge clock);
            cyc++;
        end

        chk("latency", 64'(cyc), 64'(h * (2 * n + 1) + 1));
        chk("sck_rises", 64'(rises), 64'(n));
        chk("ss_low_cycles", 64'(ss_low), 64'(h * (2 * n + 1)));
        chk("ss_value", 64'(ss_bad), 64'd0);
        chk("sck_high_width", 64'(width_bad), 64'd0);
        chk("mosi_bits", sent & mask, exp_sent);
        chk("rx_data", bus.rsp_rx_data, exp_rx);
        chk("done_pins", 64'({bus.sck, bus.mosi, bus.ss_n}), 64'({1'b0, 1'b1, 8'hFF}));
        chk("ready_in_done", 64'(bus.req_ready), 64'd0);

        if (bp > 0) begin
            stable_bad = 0;
            bus.req_valid = 1'b1;
            for (int i = 0; i < bp; i++) begin
                @(negedge clock);
                if (bus.rsp_valid !== 1'b1 || bus.rsp_rx_data !== exp_rx || bus.req_ready !== 1'b0 ||
                    bus.ss_n !== 8'hFF || bus.sck !== 1'b0)
                    stable_bad++;
            end
            chk("backpressure_hold", 64'(stable_bad), 64'd0);
            bus.req_valid = 1'b0;
            bus.rsp_ready = 1'b1;
        end
        @(negedge clock);
        chk("rsp_popped", 64'({bus.rsp_valid, bus.req_ready, bus.ss_n}), 64'({1'b0, 1'b1, 8'hFF}));
        bus.rsp_ready = 1'b1;
    endtask

    initial begin
        int rises, cyc, leak;
        logic prev_sck;
        logic [7:0] ss;

        bus.req_valid = 1'b0;
        bus.req_tx_data = '0;
        bus.req_len = '0;
        bus.req_lsb = 1'b0;
        bus.req_ss = '0;
        bus.req_div = '0;
        bus.rsp_ready = 1'b1;
`ifdef SPI_XFER_MASTER_SS_HOLD_EN
        bus.req_hold = 1'b0;
`endif
        repeat (3) @(negedge clock);
        chk("reset_pins", 64'({bus.sck, bus.mosi, bus.ss_n, bus.rsp_valid}), 64'({1'b0, 1'b1, 8'hFF, 1'b0}));
        chk("reset_rx", bus.rsp_rx_data, 64'd0);
        chk("reset_ready", 64'(bus.req_ready), 64'd1);
        reset = 1'b0;
        @(negedge clock);

        run_xfer(64'hA5, 7, 1'b0, 8'h01, 8'd0, 1'b1, 64'd0, 0);
        run_xfer(64'h00A5, 15, 1'b0, 8'h01, 8'd1, 1'b1, 64'd0, 0);
        run_xfer(64'h1, 0, 1'b1, 8'h02, 8'd2, 1'b0, 64'd0, 0);
        run_xfer({$urandom, $urandom}, 31, 1'b1, 8'h80, 8'd0, 1'b0, {$urandom, $urandom}, 10);

        // Abort an 8-bit transfer in its fourth sck-high phase.
        @(negedge clock);
        loop_mode = 1'b1;
        bus.req_tx_data = 64'hC3;
        bus.req_len = 6'd7;
        bus.req_lsb = 1'b0;
        bus.req_ss = 8'h04;
        bus.req_div = 8'd1;
        bus.req_valid = 1'b1;
        @(negedge clock);
        bus.req_valid = 1'b0;
        prev_sck = bus.sck;
        rises = 0;
        cyc = 0;
        while (rises < 4 && cyc < 200) begin
            @(negedge clock);
            cyc++;
            if (bus.sck === 1'b1 && prev_sck === 1'b0) rises++;
            prev_sck = bus.sck;
        end
        chk("abort_in_high", 64'({bus.sck, bus.ss_n}), 64'({1'b1, 8'hFB}));
        reset = 1'b1;
        #1;
        chk("abort_async_pins", 64'({bus.sck, bus.mosi, bus.ss_n, bus.rsp_valid}), 64'({1'b0, 1'b1, 8'hFF, 1'b0}));
        @(negedge clock);
        reset = 1'b0;
        leak = 0;
        repeat (40) begin
            @(negedge clock);
            if (bus.rsp_valid !== 1'b0 || bus.ss_n !== 8'hFF || bus.sck !== 1'b0) leak++;
        end
        chk("abort_no_rsp", 64'(leak), 64'd0);
        run_xfer(64'h3C, 7, 1'b0, 8'h04, 8'd1, 1'b1, 64'd0, 0);

        for (int t = 0; t < 16; t++) begin
            do ss = 8'($urandom); while (ss == 8'h00);
            run_xfer({$urandom, $urandom}, $urandom_range(0, 63), 1'($urandom), ss,
                     8'($urandom_range(0, 3)), 1'($urandom), {$urandom, $urandom},
                     ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0);
        end

        run_xfer({$urandom, $urandom}, 63, 1'b0, 8'h10, 8'hFF, 1'b1, 64'd0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
